// File: rtl/jk_counter_driver.sv
// jk_counter_driver
//    Modulo-MODULUS up/down counter whose state is held as a bank of JK
//    flip-flops. Each cycle it picks a target next state and derives the
//    per-bit J/K excitation that produces it. The counter applies the JK
//    characteristic equation to that excitation. It also exports J/K so an
//    external JK bank on the same clock can follow in lock-step, and it
//    raises a sticky error when that bank's Q diverges from the internal
//    state.
//
// Ports
//    clk       in   rising-edge clock
//    rst_n     in   asynchronous active-low reset
//    en        in   count enable
//    up        in   direction (1 = increment, 0 = decrement)
//    load      in   synchronous load, has priority over en
//    load_val  in   value to load (out-of-range values load 0)
//    chk_en    in   enables the comparison of q_ext against q
//    q_ext     in   Q of the external JK bank driven by j/k
//    q         out  counter state (registered)
//    j, k      out  excitation for the coming edge (combinational)
//    wrap      out  one-cycle pulse after a counting wrap-around (registered)
//    err       out  sticky divergence flag (registered)
module jk_counter_driver #(
   parameter int WIDTH   = 4,
   parameter int MODULUS = 10
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             chk_en,
   input  logic [WIDTH-1:0] q_ext,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] j,
   output logic [WIDTH-1:0] k,
   output logic             wrap,
   output logic             err
);

   // One extra bit so MODULUS == 2**WIDTH still compares correctly.
   localparam logic [WIDTH:0]   MOD_W  = (WIDTH+1)'(MODULUS);
   localparam logic [WIDTH-1:0] LAST_V = WIDTH'(MODULUS - 1);
   localparam logic [WIDTH-1:0] ZERO_V = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] ONE_V  = WIDTH'(1);

   logic [WIDTH-1:0] state_q, state_d;
   logic             wrap_q, wrap_d;
   logic             err_q, err_d;
   logic [WIDTH-1:0] target_s;
   logic [WIDTH-1:0] j_s, k_s;

   // JK characteristic equation applied bitwise.
   function automatic logic [WIDTH-1:0] jk_next(
      input logic [WIDTH-1:0] cur,
      input logic [WIDTH-1:0] jv,
      input logic [WIDTH-1:0] kv
   );
      return (jv & ~cur) | (~kv & cur);
   endfunction

   // Target selection: load beats count; only a counting rollover flags wrap.
   always_comb begin
      target_s = state_q;
      wrap_d   = 1'b0;
      if (load) begin
         if ({1'b0, load_val} < MOD_W) begin
            target_s = load_val;
         end else begin
            target_s = ZERO_V;
         end
      end else if (en) begin
         if (up) begin
            if (state_q == LAST_V) begin
               target_s = ZERO_V;
               wrap_d   = 1'b1;
            end else begin
               target_s = state_q + ONE_V;
            end
         end else begin
            if (state_q == ZERO_V) begin
               target_s = LAST_V;
               wrap_d   = 1'b1;
            end else begin
               target_s = state_q - ONE_V;
            end
         end
      end else begin
         target_s = state_q;
      end
   end

   // Excitation: set only 0->1 bits, reset only 1->0 bits, so J=K=1 never
   // occurs. Held at zero during reset so the external bank stays quiet.
   always_comb begin
      j_s = ZERO_V;
      k_s = ZERO_V;
      if (!rst_n) begin
         j_s = ZERO_V;
         k_s = ZERO_V;
      end else begin
         j_s = target_s & ~state_q;
         k_s = ~target_s & state_q;
      end
   end

   // Next state comes from the JK equation, not a copy of the target.
   // err is sticky and is only cleared by reset.
   always_comb begin
      state_d = jk_next(state_q, j_s, k_s);
      err_d   = err_q | (chk_en & (q_ext != state_q));
   end

   // State, wrap pulse and error flag registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ZERO_V;
         wrap_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         wrap_q  <= wrap_d;
         err_q   <= err_d;
      end
   end

   assign q    = state_q;
   assign j    = j_s;
   assign k    = k_s;
   assign wrap = wrap_q;
   assign err  = err_q;

endmodule

// File: tb/tb_jk_counter_driver.sv
// Directed test for jk_counter_driver. Each vector drives the inputs just
// after a falling edge and queues the hand-computed values expected in that
// half cycle; an independent monitor samples the DUT 2 time units later and
// compares against the queued entries.
module tb_jk_counter_driver;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       en, up, load, chk_en;
   logic [3:0] load_val, q_ext;
   logic [3:0] q, j, k;
   logic       wrap, err;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [3:0] q;
      logic [3:0] j;
      logic [3:0] k;
      logic       w;
      logic       e;
      string      nm;
   } exp_t;

   exp_t sb[$];

   jk_counter_driver #(.WIDTH(4), .MODULUS(10)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load),
      .load_val(load_val), .chk_en(chk_en), .q_ext(q_ext),
      .q(q), .j(j), .k(k), .wrap(wrap), .err(err)
   );

   always #5 clk = ~clk;

   // Monitor: samples mid-low-phase and checks every queued expectation.
   always @(negedge clk) begin
      exp_t it;
      #2;
      while (sb.size() > 0) begin
         it = sb.pop_front();
         checks += 5;
         if (q !== it.q) begin
            errors++;
            $display("FAIL %s q: got %b expected %b", it.nm, q, it.q);
         end
         if (j !== it.j) begin
            errors++;
            $display("FAIL %s j: got %b expected %b", it.nm, j, it.j);
         end
         if (k !== it.k) begin
            errors++;
            $display("FAIL %s k: got %b expected %b", it.nm, k, it.k);
         end
         if (wrap !== it.w) begin
            errors++;
            $display("FAIL %s wrap: got %b expected %b", it.nm, wrap, it.w);
         end
         if (err !== it.e) begin
            errors++;
            $display("FAIL %s err: got %b expected %b", it.nm, err, it.e);
         end
      end
   end

   // One vector: inputs for this cycle plus the q/j/k/wrap/err expected
   // before the next rising edge.
   task automatic cyc(
      input logic       r,
      input logic       e,
      input logic       u,
      input logic       l,
      input logic [3:0] lv,
      input logic       c,
      input logic [3:0] qx,
      input logic [3:0] eq,
      input logic [3:0] ej,
      input logic [3:0] ek,
      input logic       ew,
      input logic       ee,
      input string      nm
   );
      exp_t it;
      @(negedge clk);
      rst_n = r; en = e; up = u; load = l; load_val = lv; chk_en = c; q_ext = qx;
      it.q = eq; it.j = ej; it.k = ek; it.w = ew; it.e = ee; it.nm = nm;
      sb.push_back(it);
      #3;
   endtask

   initial begin
      rst_n = 1'b0; en = 1'b0; up = 1'b0; load = 1'b0;
      load_val = 4'd0; chk_en = 1'b0; q_ext = 4'd0;

      // reset: j/k forced low even with en=1
      cyc(1'b0,1'b1,1'b1,1'b0,4'd0,1'b1,4'd0, 4'd0,4'b0000,4'b0000,1'b0,1'b0,"reset");
      // up-count 0..9,0,1 (q_ext follows expected q, chk_en on)
      cyc(1'b1,1'b1,1'b1,1'b0,4'd0,1'b1,4'd0, 4'd0,4'b0001,4'b0000,1'b0,1'b0,"up0");
      cyc(1'b1,1'b1,1'b1,1'b0,4'd0,1'b1,4'd1, 4'd1,4'b0010,4'b0001,1'b0,1'b0,"up1");
      cyc(1'b1,1'b1,1'b1,1'b0,4'd0,1'b1,4'd2, 4'd2,4'b0001,4'b0000,1'b0,1'b0,"up2");
      cyc(1'b1,1'b1,1'b1,1'b0,4'd0,1'b1,4'd3, 4'd3,4'b0100,4'b0011,1'b0,1'b0,"up3");
      cyc(1'b1,1'b1,1'b1,1'b0,4'd0,1'b1,4'd4, 4'd4,4'b0001,4'b0000,1'b0,1'b0,"up4");
      cyc(1'b1,1'b1,1'b1,1'b0,4'd0,1'b1,4'd5, 4'd5,4'b0010,4'b0001,1'b0,1'b0,"up5");
      cyc(1'b1,1'b1,1'b1,1'b0,4'd0,1'b1,4'd6, 4'd6,4'b0001,4'b0000,1'b0,1'b0,"up6");
      cyc(1'b1,1'b1,1'b1,1'b0,4'd0,1'b1,4'd7, 4'd7,4'b1000,4'b0111,1'b0,1'b0,"up7");
      cyc(1'b1,1'b1,1'b1,1'b0,4'd0,1'b1,4'd8, 4'd8,4'b0001,4'b0000,1'b0,1'b0,"up8");
      cyc(1'b1,1'b1,1'b1,1'b0,4'd0,1'b1,4'd9, 4'd9,4'b0000,4'b1001,1'b0,1'b0,"up9");
      cyc(1'b1,1'b1,1'b1,1'b0,4'd0,1'b1,4'd0, 4'd0,4'b0001,4'b0000,1'b1,1'b0,"upwrap");
      cyc(1'b1,1'b1,1'b1,1'b0,4'd0,1'b1,4'd1, 4'd1,4'b0010,4'b0001,1'b0,1'b0,"upwrap_clr");
      cyc(1'b1,1'b1,1'b1,1'b0,4'd0,1'b1,4'd2, 4'd2,4'b0001,4'b0000,1'b0,1'b0,"up2b");
      cyc(1'b1,1'b1,1'b1,1'b0,4'd0,1'b1,4'd3, 4'd3,4'b0100,4'b0011,1'b0,1'b0,"up3b");
      // hold at q=4 for 5 cycles
      for (int i = 0; i < 5; i++)
         cyc(1'b1,1'b0,1'b1,1'b0,4'd0,1'b1,4'd4, 4'd4,4'b0000,4'b0000,1'b0,1'b0,"hold");
      // loads
      cyc(1'b1,1'b0,1'b0,1'b1,4'd7,1'b1,4'd4, 4'd4,4'b0011,4'b0000,1'b0,1'b0,"load7");
      cyc(1'b1,1'b0,1'b0,1'b1,4'd12,1'b1,4'd7, 4'd7,4'b0000,4'b0111,1'b0,1'b0,"load12");
      cyc(1'b1,1'b0,1'b0,1'b1,4'd9,1'b1,4'd0, 4'd0,4'b1001,4'b0000,1'b0,1'b0,"load9");
      cyc(1'b1,1'b1,1'b1,1'b1,4'd3,1'b1,4'd9, 4'd9,4'b0010,4'b1000,1'b0,1'b0,"load3_en");
      cyc(1'b1,1'b0,1'b0,1'b1,4'd9,1'b1,4'd3, 4'd3,4'b1000,4'b0010,1'b0,1'b0,"load9b");
      cyc(1'b1,1'b1,1'b1,1'b1,4'd0,1'b1,4'd9, 4'd9,4'b0000,4'b1001,1'b0,1'b0,"load0_en");
      // down-count with wrap, then up from 8
      cyc(1'b1,1'b1,1'b0,1'b0,4'd0,1'b1,4'd0, 4'd0,4'b1001,4'b0000,1'b0,1'b0,"dn0");
      cyc(1'b1,1'b1,1'b0,1'b0,4'd0,1'b1,4'd9, 4'd9,4'b0000,4'b0001,1'b1,1'b0,"dnwrap");
      cyc(1'b1,1'b1,1'b1,1'b0,4'd0,1'b1,4'd8, 4'd8,4'b0001,4'b0000,1'b0,1'b0,"up_from8");
      cyc(1'b1,1'b1,1'b1,1'b0,4'd0,1'b1,4'd9, 4'd9,4'b0000,4'b1001,1'b0,1'b0,"up9b");
      // fault with chk_en=0: ignored
      cyc(1'b1,1'b0,1'b1,1'b0,4'd0,1'b0,4'd4, 4'd0,4'b0000,4'b0000,1'b1,1'b0,"fault_nochk");
      cyc(1'b1,1'b0,1'b1,1'b0,4'd0,1'b1,4'd0, 4'd0,4'b0000,4'b0000,1'b0,1'b0,"nochk_ok");
      // fault with chk_en=1: err sets next edge and stays
      cyc(1'b1,1'b0,1'b1,1'b0,4'd0,1'b1,4'd4, 4'd0,4'b0000,4'b0000,1'b0,1'b0,"fault_chk");
      cyc(1'b1,1'b0,1'b1,1'b0,4'd0,1'b1,4'd0, 4'd0,4'b0000,4'b0000,1'b0,1'b1,"err_set");
      cyc(1'b1,1'b1,1'b1,1'b0,4'd0,1'b0,4'd0, 4'd0,4'b0001,4'b0000,1'b0,1'b1,"err_sticky");
      cyc(1'b1,1'b1,1'b1,1'b0,4'd0,1'b0,4'd0, 4'd1,4'b0010,4'b0001,1'b0,1'b1,"c1");
      cyc(1'b1,1'b1,1'b1,1'b0,4'd0,1'b0,4'd0, 4'd2,4'b0001,4'b0000,1'b0,1'b1,"c2");
      cyc(1'b1,1'b1,1'b1,1'b0,4'd0,1'b0,4'd0, 4'd3,4'b0100,4'b0011,1'b0,1'b1,"c3");
      cyc(1'b1,1'b1,1'b1,1'b0,4'd0,1'b0,4'd0, 4'd4,4'b0001,4'b0000,1'b0,1'b1,"c4");
      cyc(1'b1,1'b1,1'b1,1'b0,4'd0,1'b0,4'd0, 4'd5,4'b0010,4'b0001,1'b0,1'b1,"c5");
      cyc(1'b1,1'b0,1'b1,1'b0,4'd0,1'b0,4'd0, 4'd6,4'b0000,4'b0000,1'b0,1'b1,"hold6");
      // async reset between edges at q=6
      cyc(1'b0,1'b1,1'b1,1'b0,4'd0,1'b1,4'd6, 4'd0,4'b0000,4'b0000,1'b0,1'b0,"async_rst");
      cyc(1'b1,1'b1,1'b1,1'b0,4'd0,1'b1,4'd0, 4'd0,4'b0001,4'b0000,1'b0,1'b0,"rst_rel");
      cyc(1'b1,1'b1,1'b1,1'b0,4'd0,1'b1,4'd1, 4'd1,4'b0010,4'b0001,1'b0,1'b0,"resume1");
      cyc(1'b1,1'b0,1'b1,1'b0,4'd0,1'b1,4'd2, 4'd2,4'b0000,4'b0000,1'b0,1'b0,"resume2");

      repeat (2) @(negedge clk);
      #4;
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending expected 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
